pic_priority_sequencer: RTL and testbench

PIC_PRIORITY_SEQUENCER -- requirements
Module: pic_priority_sequencer

---
 rtl/pic_priority_sequencer.sv | 151 +++++++++++++++
 tb/tb_pic_priority_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_sequencer.sv
// Eight-input, fully nested priority interrupt sequencer.
// Detects request edges, arbitrates against the in-service set, and runs the acknowledge handshake.
module pic_priority_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir_i,
    input  logic [7:0] imr_i,
    input  logic [4:0] vector_base_i,
    input  logic       intack_i,
    input  logic       eoi_i,
    output logic       int_o,
    output logic [7:0] vec_o,
    output logic       vec_valid_o,
    output logic [7:0] irr_o,
    output logic [7:0] isr_o,
    output logic       ack_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        HOLD
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] ir_prev_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ack_err_q, ack_err_d;

    logic [7:0] ir_rise;
    logic [7:0] blocked;
    logic [7:0] eligible;
    logic       win_valid;
    logic [2:0] win_idx;
    logic       grant;
    logic [7:0] grant_onehot;
    logic [7:0] eoi_clear;

    assign ir_rise = ir_i & ~ir_prev_q;

    // blocked[i] is set when any in-service level at or above priority i is active.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blocked = '0;
        for (int i = 0; i < 8; i++) begin
            seen       = seen | isr_q[i];
            blocked[i] = seen;
        end
    end

    assign eligible = irr_q & ~imr_i & ~blocked;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    assign grant_onehot = grant ? (8'b1 << win_idx) : 8'h00;
    assign eoi_clear    = eoi_i ? (isr_q & (~isr_q + 8'd1)) : 8'h00;

    // EOI retires the pre-grant in-service bit; a new edge outranks the grant's clear.
    assign isr_d = (isr_q & ~eoi_clear) | grant_onehot;
    assign irr_d = (irr_q & ~grant_onehot) | ir_rise;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        ack_err_d = ack_err_q;
        grant     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!win_valid) begin
                    state_d = IDLE;
                end else if (intack_i) begin
                    grant   = 1'b1;
                    vec_d   = {vector_base_i, win_idx};
                    state_d = ACK;
                end
            end
            ACK: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!intack_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    // CPU never released acknowledge; abandon the cycle but leave the level in service.
                    cnt_d     = '0;
                    ack_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir_prev_q <= '0;
            irr_q     <= '0;
            isr_q     <= '0;
            vec_q     <= '0;
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_prev_q <= ir_i;
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign int_o       = (state_q == REQ);
    assign vec_valid_o = (state_q == ACK);
    assign vec_o       = vec_q;
    assign irr_o       = irr_q;
    assign isr_o       = isr_q;
    assign ack_err_o   = ack_err_q;

endmodule

// File: tb/tb_pic_priority_sequencer.sv
// Directed and randomized bench for pic_priority_sequencer, compared cycle by cycle
// against a behavioural model of the request/in-service/handshake rules.
module tb_pic_priority_sequencer;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] ir, imr;
    logic [4:0] vb;
    logic       intack, eoi;
    logic       intO, vecValid, ackErr;
    logic [7:0] vec, irr, isr;

    int checks = 0;
    int failures = 0;

    // behavioural model: pending/in-service sets plus what the CPU currently sees
    bit [7:0] mPrev, mReq, mSvc, mVec;
    bit       mIntAsserted, mStrobe, mAwaitRelease, mErr;
    int       mWait;

    always #5 clk = ~clk;

    pic_priority_sequencer #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .ir_i         (ir),
        .imr_i        (imr),
        .vector_base_i(vb),
        .intack_i     (intack),
        .eoi_i        (eoi),
        .int_o        (intO),
        .vec_o        (vec),
        .vec_valid_o  (vecValid),
        .irr_o        (irr),
        .isr_o        (isr),
        .ack_err_o    (ackErr)
    );

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".int"}, {7'd0, intO}, {7'd0, mIntAsserted});
        chk({tag, ".vecValid"}, {7'd0, vecValid}, {7'd0, mStrobe});
        chk({tag, ".vec"}, vec, mVec);
        chk({tag, ".irr"}, irr, mReq);
        chk({tag, ".isr"}, isr, mSvc);
        chk({tag, ".ackErr"}, {7'd0, ackErr}, {7'd0, mErr});
    endtask

    task automatic modelReset();
        mPrev = '0; mReq = '0; mSvc = '0; mVec = '0;
        mIntAsserted = 0; mStrobe = 0; mAwaitRelease = 0; mErr = 0; mWait = 0;
    endtask

    // drive one cycle of inputs, advance the model by one clock, then compare
    task automatic applyStimulus(input logic [7:0] irV, input logic [7:0] imrV, input logic [4:0] baseV,
                                 input logic ackV, input logic eoiV, input string tag);
        int winner;
        bit busy, grant, found;
        bit [7:0] nReq, nSvc, nVec;
        bit nInt, nStrobe, nAwait, nErr;
        int nWait;
        ir = irV; imr = imrV; vb = baseV; intack = ackV; eoi = eoiV;

        winner = -1;
        for (int i = 0; i < 8; i++) begin
            busy = 0;
            for (int j = 0; j <= i; j++) busy = busy | mSvc[j];
            if (winner < 0 && mReq[i] && !imrV[i] && !busy) winner = i;
        end
        grant = mIntAsserted && ackV && (winner >= 0);

        nSvc = mSvc;
        found = 0;
        if (eoiV) begin
            for (int i = 0; i < 8; i++) begin
                if (!found && nSvc[i]) begin
                    nSvc[i] = 0;
                    found = 1;
                end
            end
        end
        if (grant) nSvc[winner] = 1;
        nReq = mReq;
        if (grant) nReq[winner] = 0;
        nReq = nReq | (irV & ~mPrev);

        nInt = 0; nStrobe = 0; nAwait = mAwaitRelease; nWait = mWait; nVec = mVec; nErr = mErr;
        if (mStrobe) begin
            nAwait = 1; nWait = 0;
        end else if (mAwaitRelease) begin
            if (!ackV) begin
                nAwait = 0; nWait = 0;
            end else if (mWait + 1 == TIMEOUT) begin
                nAwait = 0; nWait = 0; nErr = 1;
            end else begin
                nWait = mWait + 1;
            end
        end else if (mIntAsserted) begin
            if (winner < 0) nInt = 0;
            else if (ackV) begin
                nStrobe = 1;
                nVec = {baseV, 3'(winner)};
            end else nInt = 1;
        end else begin
            nInt = (winner >= 0);
        end

        @(posedge clk);
        #1;
        mPrev = irV; mReq = nReq; mSvc = nSvc; mVec = nVec;
        mIntAsserted = nInt; mStrobe = nStrobe; mAwaitRelease = nAwait; mWait = nWait; mErr = nErr;
        checkOutput(tag);
    endtask

    task automatic quiet(input int n, input string tag);
        for (int k = 0; k < n; k++) applyStimulus(8'h00, 8'h00, 5'h08, 1'b0, 1'b0, tag);
    endtask

    task automatic pulseReset(input logic [7:0] irDuring, input string tag);
        rstN = 1'b0;
        ir = irDuring;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        logic       ackHold;
        logic [7:0] irR, imrR;
        rstN = 1'b1; ir = '0; imr = '0; vb = 5'h08; intack = 0; eoi = 0;
        $display("[TB] start");
        #2;
        pulseReset(8'h00, "reset");
        chk("resetInt", {7'd0, intO}, 8'h00);
        chk("resetIrr", irr, 8'h00);

        // single request on IR2 through the full handshake
        applyStimulus(8'h04, 8'h00, 5'h08, 0, 0, "ir2Edge");
        chk("ir2IrrSet", irr, 8'h04);
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 0, "ir2Req");
        chk("ir2IntHigh", {7'd0, intO}, 8'h01);
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "ir2Ack");
        chk("ir2Vec", vec, 8'h42);
        chk("ir2Strobe", {7'd0, vecValid}, 8'h01);
        chk("ir2Isr", isr, 8'h04);
        chk("ir2IrrClear", irr, 8'h00);
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 0, "ir2Hold");
        chk("ir2StrobeOnce", {7'd0, vecValid}, 8'h00);
        quiet(1, "ir2Idle");
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "ir2Eoi");

        // IR4 and IR7 together: IR7 waits for EOI of IR4
        applyStimulus(8'h90, 8'h00, 5'h08, 0, 0, "dualEdge");
        quiet(1, "dualReq");
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "dualAck4");
        chk("dualVec4", vec, 8'h44);
        quiet(2, "dualRelease");
        for (int k = 0; k < 3; k++) begin
            quiet(1, "ir7Wait");
            chk("ir7Blocked", {7'd0, intO}, 8'h00);
        end
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "dualEoi4");
        quiet(1, "ir7Req");
        chk("ir7AfterEoi", {7'd0, intO}, 8'h01);
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "dualAck7");
        chk("dualVec7", vec, 8'h47);
        quiet(2, "dualRelease7");
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "dualEoi7");

        // nesting: IR5 in service, IR2 preempts, IR6 waits for both EOIs
        applyStimulus(8'h20, 8'h00, 5'h08, 0, 0, "nestEdge5");
        quiet(1, "nestReq5");
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "nestAck5");
        quiet(2, "nestRel5");
        applyStimulus(8'h04, 8'h00, 5'h08, 0, 0, "nestEdge2");
        quiet(1, "nestReq2");
        chk("ir2Preempts", {7'd0, intO}, 8'h01);
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "nestAck2");
        chk("nestIsr", isr, 8'h24);
        quiet(2, "nestRel2");
        applyStimulus(8'h40, 8'h00, 5'h08, 0, 0, "nestEdge6");
        quiet(2, "nestWait6");
        chk("ir6Blocked", {7'd0, intO}, 8'h00);
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "nestEoi2");
        chk("nestEoiLowest", isr, 8'h20);
        quiet(1, "nestStill");
        chk("ir6StillBlocked", {7'd0, intO}, 8'h00);
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "nestEoi5");
        quiet(1, "nestReq6");
        chk("ir6AfterEoi", {7'd0, intO}, 8'h01);
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "nestAck6");
        chk("nestVec6", vec, 8'h46);
        quiet(2, "nestRel6");
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "nestEoi6");

        // masking a pending request while int is raised
        applyStimulus(8'h01, 8'h00, 5'h08, 0, 0, "maskEdge");
        quiet(1, "maskReq");
        applyStimulus(8'h00, 8'hFF, 5'h08, 0, 0, "maskAll");
        chk("maskIntDrop", {7'd0, intO}, 8'h00);
        chk("maskIrrKept", irr, 8'h01);
        applyStimulus(8'h00, 8'hFF, 5'h08, 1, 0, "maskAckIgnored");
        chk("maskNoVec", {7'd0, vecValid}, 8'h00);
        quiet(1, "maskReReq");
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "maskAck");
        chk("maskVec", vec, 8'h40);
        quiet(2, "maskRel");
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 1, "maskEoi");

        // acknowledge held past the timeout
        applyStimulus(8'h02, 8'h00, 5'h08, 0, 0, "toEdge");
        quiet(1, "toReq");
        applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "toAck");
        chk("toVec", vec, 8'h41);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(8'h00, 8'h00, 5'h08, 1, 0, "toHold");
            chk("toAckErrTiming", {7'd0, ackErr}, (k >= TIMEOUT) ? 8'h01 : 8'h00);
        end
        chk("toIntLow", {7'd0, intO}, 8'h00);
        applyStimulus(8'h00, 8'h00, 5'h08, 0, 0, "toRelease");
        chk("toIsrKept", isr, 8'h02);
        pulseReset(8'h00, "toReset");
        chk("toAckErrCleared", {7'd0, ackErr}, 8'h00);

        // reset in the middle of a handshake, with IR4 already high at release
        applyStimulus(8'h08, 8'h00, 5'h08, 0, 0, "rstEdge");
        quiet(1, "rstReq");
        applyStimulus(8'h08, 8'h00, 5'h08, 1, 0, "rstAck");
        applyStimulus(8'h08, 8'h00, 5'h08, 1, 0, "rstHold");
        pulseReset(8'h10, "rstMidHold");
        chk("rstIsr", isr, 8'h00);
        applyStimulus(8'h10, 8'h00, 5'h08, 0, 0, "rstReleaseEdge");
        chk("rstIrHighIsEdge", irr, 8'h10);
        chk("rstNoStrobe", {7'd0, vecValid}, 8'h00);

        // randomized traffic
        ackHold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) ackHold = ~ackHold;
            irR  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            imrR = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
            applyStimulus(irR, imrR, 5'($urandom), ackHold, ($urandom_range(0, 7) == 0), "rand");
            if (n == 300) pulseReset(8'($urandom), "randReset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
